// File: rtl/branch_predictor_table.sv
// branch_predictor_table: table of saturating counters indexed by PC, optionally
// XORed with a global history register (bimodal when HISTORY_BITS=0, gshare
// otherwise). Lookup is combinational from registered state; training arrives
// from the memory stage with the index captured at decode. Also keeps
// saturating branch / mispredict performance counters.
module branch_predictor_table #(
  parameter int INDEX_BITS   = 6,
  parameter int HISTORY_BITS = 0,
  parameter int COUNTER_BITS = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  input  logic [ADDR_WIDTH-1:0] i_lookup_offset,
  output logic                  o_prediction,
  output logic [ADDR_WIDTH-1:0] o_branch_addr,
  output logic [INDEX_BITS-1:0] o_lookup_index,
  input  logic                  i_update_valid,
  input  logic [INDEX_BITS-1:0] i_update_index,
  input  logic                  i_update_taken,
  input  logic                  i_update_mispredict,
  output logic [31:0]           o_perf_branches,
  output logic [31:0]           o_perf_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
  // Weakly not-taken: all ones shifted right once gives 2^(COUNTER_BITS-1)-1.
  localparam logic [COUNTER_BITS-1:0] CNT_INIT = CNT_MAX >> 1;
  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  logic [COUNTER_BITS-1:0] r_counters [ENTRIES];
  logic [31:0]             r_perf_branches;
  logic [31:0]             r_perf_mispredicts;

  logic [INDEX_BITS-1:0]   w_hist_xor;
  logic [INDEX_BITS-1:0]   w_pc_index;
  logic [COUNTER_BITS-1:0] w_lookup_cnt;
  logic [COUNTER_BITS-1:0] w_upd_cnt;
  logic [COUNTER_BITS-1:0] w_upd_next;

  // Global history exists only in gshare mode; bimodal contributes no XOR term.
  generate
    if (HISTORY_BITS > 0) begin : g_history
      logic [HISTORY_BITS-1:0] r_ghr;

      // Shift in resolved outcomes only; history is never speculative.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_ghr <= '0;
        end else if (i_update_valid) begin
          if (HISTORY_BITS == 1) begin
            r_ghr <= i_update_taken;
          end else begin
            r_ghr <= {r_ghr[HISTORY_BITS-2:0], i_update_taken};
          end
        end
      end

      assign w_hist_xor = INDEX_BITS'(r_ghr);
    end else begin : g_no_history
      assign w_hist_xor = '0;
    end
  endgenerate

  // Lookup path: index, counter read and target are all combinational.
  assign w_pc_index     = i_lookup_pc[INDEX_BITS+1:2];
  assign o_lookup_index = w_pc_index ^ w_hist_xor;
  assign w_lookup_cnt   = r_counters[o_lookup_index];
  assign o_prediction   = i_lookup_valid & w_lookup_cnt[COUNTER_BITS-1];
  assign o_branch_addr  = i_lookup_pc + i_lookup_offset;

  assign w_upd_cnt = r_counters[i_update_index];

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    w_upd_next = w_upd_cnt;
    if (i_update_taken) begin
      if (w_upd_cnt != CNT_MAX) begin
        w_upd_next = w_upd_cnt + COUNTER_BITS'(1);
      end
    end else begin
      if (w_upd_cnt != '0) begin
        w_upd_next = w_upd_cnt - COUNTER_BITS'(1);
      end
    end
  end

  // Counter table: flops rather than RAM so the whole table clears on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_counters[i] <= CNT_INIT;
      end
    end else if (i_update_valid) begin
      r_counters[i_update_index] <= w_upd_next;
    end
  end

  // Performance counters, saturating at all ones; mispredict needs update_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else if (i_update_valid) begin
      if (r_perf_branches != PERF_MAX) begin
        r_perf_branches <= r_perf_branches + 32'd1;
      end
      if (i_update_mispredict && (r_perf_mispredicts != PERF_MAX)) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign o_perf_branches    = r_perf_branches;
  assign o_perf_mispredicts = r_perf_mispredicts;

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised dynamic branch predictor for the 5-stage RV32 pipeline, replacing the single global 2-bit FSM predictor. Holds a table of 2^INDEX_BITS saturating counters, indexed by PC optionally XORed with a global history register (bimodal when HISTORY_BITS=0, gshare otherwise). Issues a taken/not-taken prediction and target address to the fetch mux during decode. Trains from the memory stage using the index carried down the pipeline with the branch. Also keeps branch and mispredict performance counters.

## Interface

- INDEX_BITS, 6, log2 of table entries; legal range 1..10.
- HISTORY_BITS, 0, global history length; 0 = bimodal; legal range 0..INDEX_BITS.
- COUNTER_BITS, 2, saturating counter width; legal range 1..4.
- ADDR_WIDTH, 32, PC/offset/target width.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_valid  in  1  decode-stage instruction is a conditional branch.
- lookup_pc  in  ADDR_WIDTH  PC of the decode-stage instruction.
- lookup_offset  in  ADDR_WIDTH  sign-extended B-type immediate.
- prediction  out  1  predict taken; gated by lookup_valid.
- branch_addr  out  ADDR_WIDTH  lookup_pc + lookup_offset, modulo 2^ADDR_WIDTH.
- lookup_index  out  INDEX_BITS  table index used; carried ID->EX->MEM by the pipeline.
- update_valid  in  1  memory-stage instruction is a resolved conditional branch.
- update_index  in  INDEX_BITS  lookup_index captured when that branch was in decode.
- update_taken  in  1  actual branch outcome.
- update_mispredict  in  1  resolved outcome differed from prediction.
- perf_branches  out  32  resolved-branch count.
- perf_mispredicts  out  32  mispredict count.

## Operation

- Index: lookup_index = lookup_pc[INDEX_BITS+1:2] XOR zero-extended ghr[HISTORY_BITS-1:0]. With HISTORY_BITS=0 there is no ghr and the XOR term is absent.
- prediction = lookup_valid & counter[lookup_index][COUNTER_BITS-1] (MSB of the counter).
- branch_addr is computed regardless of lookup_valid.
- Training, on update_valid at a rising edge:
  - counter[update_index] increments if update_taken, otherwise decrements.
  - The counter saturates at 2^COUNTER_BITS-1 and at 0; it never wraps.
  - ghr <= {ghr[HISTORY_BITS-2:0], update_taken}.
  - History updates are non-speculative. Only resolved branches shift history; flushed branches never reach the update port.
- Perf counters:
  - perf_branches += 1 on each update_valid.
  - perf_mispredicts += 1 on update_valid & update_mispredict.
  - Both saturate at 0xFFFFFFFF.
  - update_mispredict without update_valid is ignored.
- Reset values:
  - Every counter = 2^(COUNTER_BITS-1)-1 (weakly not-taken; 1 for 2-bit, 0 for 1-bit).
  - ghr = 0, perf_branches = 0, perf_mispredicts = 0.
  - Hence prediction = 0 from reset.
- Reset mid-operation: all state clears asynchronously on rst_n falling, independent of clk. No update is applied on an edge while rst_n is low.

## Timing

- Lookup is combinational from registered state. Zero-cycle latency: prediction, branch_addr and lookup_index are valid in the same cycle as lookup_pc.
- Update takes effect at the rising edge where update_valid=1. Lookups see the new counter and ghr from the following cycle.
- Simultaneous lookup and update to the same index in one cycle: lookup returns the pre-update counter. There is no bypass.
- Simultaneous lookup and update in gshare mode: lookup_index uses the pre-shift ghr.
- One update per cycle. Back-to-back updates to the same index each apply in sequence. Example: 2-bit counter at 1 with two taken updates -> 3.
- No handshake: update_valid is a single-cycle pulse per resolved branch, and the block always accepts it.

## Test plan

- Reset/default: INDEX_BITS=6, HISTORY_BITS=0. Deassert rst_n, then lookup_pc=0x100, offset=0x20, lookup_valid=1 -> prediction=0, branch_addr=0x120, lookup_index=0x00. With lookup_valid=0, prediction stays 0.
- Saturation: 3 taken updates to index 5 -> a lookup at PC 0x14 predicts 1 and the counter is 3. Then 4 not-taken updates -> prediction 0 and the counter is 0. A fifth not-taken update keeps the counter at 0.
- Gshare indexing: HISTORY_BITS=4. Send updates with taken=1,0,1,1 -> ghr=4'b1011. A lookup at PC 0x40 gives lookup_index = 0x10 ^ 0x0B = 0x1B.
- Same-cycle hazard: index 3 counter at 1. Drive a lookup at PC 0x0C together with a taken update to index 3 -> prediction=0 in that cycle and prediction=1 in the next cycle.
- Perf counters: 10 updates with 3 mispredicts -> perf_branches=10, perf_mispredicts=3. Force both counters near 0xFFFFFFFF and apply one more mispredict update -> both hold 0xFFFFFFFF.
- Async reset mid-run: after training, pull rst_n low between clock edges -> all outputs return to reset values immediately, before the next edge. An update_valid pulse while rst_n is low has no effect.
